// File: rtl/display_pkg.sv
// Shared VGA timing constants, colour type and bar helper for the EBI display driver.
// Optional VGA_BORDER_EN build draws a white frame around the visible area.
package display_pkg;

   localparam int H_VIS        = 640;
   localparam int H_FP         = 16;
   localparam int H_SYNC       = 96;
   localparam int H_BP         = 48;
   localparam int H_TOTAL      = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int H_SYNC_START = H_VIS + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

   localparam int V_VIS        = 480;
   localparam int V_FP         = 10;
   localparam int V_SYNC       = 2;
   localparam int V_BP         = 33;
   localparam int V_TOTAL      = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int V_SYNC_START = V_VIS + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

   localparam int PIX_DIV  = 4;
   localparam int BAR_W    = 40;
   localparam int NUM_REGS = 16;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   // x / BAR_W by comparison chain, avoids a generic divider
   function automatic logic [3:0] bar_index(input logic [9:0] x);
      logic [3:0] idx;
      idx = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
         if (x >= 10'(i * BAR_W)) idx = 4'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/vga_timing.sv
// 640x480@60 scan generator: 25 MHz pixel enable from 100 MHz, h/v counters and
// combinational sync/visible flags that the top registers on the pixel enable.
module vga_timing
   import display_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   output logic       o_pix_en,
   output logic [9:0] o_x,
   output logic [9:0] o_y,
   output logic       o_visible,
   output logic       o_hsync_n,
   output logic       o_vsync_n
);

   logic [1:0] r_div;
   logic [9:0] r_h;
   logic [9:0] r_v;
   logic       w_pix_en;
   logic       w_h_last;
   logic       w_v_last;

   assign w_pix_en = (r_div == 2'(PIX_DIV - 1));
   assign w_h_last = (r_h == 10'(H_TOTAL - 1));
   assign w_v_last = (r_v == 10'(V_TOTAL - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_div <= '0;
      end else if (w_pix_en) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + 2'd1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_h <= '0;
         r_v <= '0;
      end else if (w_pix_en) begin
         if (w_h_last) begin
            r_h <= '0;
            r_v <= w_v_last ? 10'd0 : r_v + 10'd1;
         end else begin
            r_h <= r_h + 10'd1;
         end
      end
   end

   assign o_pix_en  = w_pix_en;
   assign o_x       = r_h;
   assign o_y       = r_v;
   assign o_visible = (r_h < 10'(H_VIS)) && (r_v < 10'(V_VIS));
   assign o_hsync_n = !((r_h >= 10'(H_SYNC_START)) && (r_h < 10'(H_SYNC_END)));
   assign o_vsync_n = !((r_v >= 10'(V_SYNC_START)) && (r_v < 10'(V_SYNC_END)));

endmodule

// File: rtl/ebi_vga_display_driver.sv
// EBI-written 16-entry colour register file driving 16 VGA colour bars.
// Define VGA_BORDER_EN to overlay a white border on the visible area edges.
module ebi_vga_display_driver
   import display_pkg::*;
(
   input  logic        clk_100m,
   input  logic        btn_rst,
   input  logic [15:0] EBI_AD,
   input  logic        EBI_ALE,
   input  logic        EBI_CS,
   input  logic        EBI_RE,
   input  logic        EBI_WE,
   output logic        vga_hsync,
   output logic        vga_vsync,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b
);

   logic [15:0] r_ad_s1;
   logic [15:0] r_ad_s2;
   logic [2:0]  r_ctl_s1;
   logic [2:0]  r_ctl_s2;
   logic        r_ale_d;
   logic        r_we_d;
   logic [3:0]  r_addr;
   logic        r_addr_valid;
   rgb444_t     r_regs [NUM_REGS];
   rgb444_t     r_rgb;
   logic        r_hsync;
   logic        r_vsync;

   logic        w_ale;
   logic        w_cs_n;
   logic        w_we;
   logic        w_ale_rise;
   logic        w_we_rise;
   logic        w_pix_en;
   logic [9:0]  w_x;
   logic [9:0]  w_y;
   logic        w_visible;
   logic        w_hsync_n;
   logic        w_vsync_n;
   logic [3:0]  w_bar;
   rgb444_t     w_col;
   logic        w_unused_re;

   assign w_unused_re = EBI_RE;

   // Strobes idle high, so reset them high to avoid a false edge on release
   always_ff @(posedge clk_100m or negedge btn_rst) begin
      if (!btn_rst) begin
         r_ad_s1  <= '0;
         r_ad_s2  <= '0;
         r_ctl_s1 <= '1;
         r_ctl_s2 <= '1;
         r_ale_d  <= 1'b1;
         r_we_d   <= 1'b1;
      end else begin
         r_ad_s1  <= EBI_AD;
         r_ad_s2  <= r_ad_s1;
         r_ctl_s1 <= {EBI_ALE, EBI_CS, EBI_WE};
         r_ctl_s2 <= r_ctl_s1;
         r_ale_d  <= w_ale;
         r_we_d   <= w_we;
      end
   end

   assign w_ale      = r_ctl_s2[2];
   assign w_cs_n     = r_ctl_s2[1];
   assign w_we       = r_ctl_s2[0];
   assign w_ale_rise = w_ale && !r_ale_d;
   assign w_we_rise  = w_we && !r_we_d;

   always_ff @(posedge clk_100m or negedge btn_rst) begin
      if (!btn_rst) begin
         r_addr       <= '0;
         r_addr_valid <= 1'b0;
      end else if (w_ale_rise && !w_cs_n) begin
         r_addr       <= r_ad_s2[3:0];
         r_addr_valid <= (r_ad_s2[15:4] == 12'd0);
      end
   end

   always_ff @(posedge clk_100m or negedge btn_rst) begin
      if (!btn_rst) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else if (w_we_rise && !w_cs_n && r_addr_valid) begin
         r_regs[r_addr] <= rgb444_t'(r_ad_s2[11:0]);
      end
   end

   vga_timing u_timing (
      .i_clk     (clk_100m),
      .i_rst_n   (btn_rst),
      .o_pix_en  (w_pix_en),
      .o_x       (w_x),
      .o_y       (w_y),
      .o_visible (w_visible),
      .o_hsync_n (w_hsync_n),
      .o_vsync_n (w_vsync_n)
   );

   assign w_bar = bar_index(w_x);

   always_comb begin
      w_col = r_regs[w_bar];
`ifdef VGA_BORDER_EN
      if ((w_x == 10'd0) || (w_x == 10'(H_VIS - 1)) ||
          (w_y == 10'd0) || (w_y == 10'(V_VIS - 1))) begin
         w_col = '1;
      end
`else
      w_col = r_regs[w_bar];
`endif
   end

   // Sync and colour share one pixel of latency from the counters
   always_ff @(posedge clk_100m or negedge btn_rst) begin
      if (!btn_rst) begin
         r_rgb   <= '0;
         r_hsync <= 1'b1;
         r_vsync <= 1'b1;
      end else if (w_pix_en) begin
         r_rgb   <= w_visible ? w_col : '0;
         r_hsync <= w_hsync_n;
         r_vsync <= w_vsync_n;
      end
   end

   assign vga_hsync = r_hsync;
   assign vga_vsync = r_vsync;
   assign vga_r     = r_rgb.r;
   assign vga_g     = r_rgb.g;
   assign vga_b     = r_rgb.b;

endmodule

// File: tb/tb_ebi_vga_display_driver.sv
// Directed scoreboard bench: EBI writes update a reference register model,
// expected pixels are queued and compared when the scan reaches them.
module tb_ebi_vga_display_driver;

   logic        clk = 1'b0;
   logic        btn_rst;
   logic [15:0] EBI_AD;
   logic        EBI_ALE;
   logic        EBI_CS;
   logic        EBI_RE;
   logic        EBI_WE;
   logic        vga_hsync;
   logic        vga_vsync;
   logic [3:0]  vga_r;
   logic [3:0]  vga_g;
   logic [3:0]  vga_b;

   always #5 clk = ~clk;

   ebi_vga_display_driver dut (
      .clk_100m  (clk),
      .btn_rst   (btn_rst),
      .EBI_AD    (EBI_AD),
      .EBI_ALE   (EBI_ALE),
      .EBI_CS    (EBI_CS),
      .EBI_RE    (EBI_RE),
      .EBI_WE    (EBI_WE),
      .vga_hsync (vga_hsync),
      .vga_vsync (vga_vsync),
      .vga_r     (vga_r),
      .vga_g     (vga_g),
      .vga_b     (vga_b)
   );

   int cyc;
   always @(posedge clk or negedge btn_rst) begin
      if (!btn_rst) cyc <= 0;
      else cyc <= cyc + 1;
   end

   typedef struct {
      int         x;
      int         y;
      logic [11:0] rgb;
      logic       hs;
      logic       vs;
   } exp_t;

   exp_t        sb[$];
   logic [11:0] m_regs[16];
   logic [3:0]  m_addr;
   logic        m_valid;
   int          total = 0;
   int          bad = 0;
   int          xs[27] = '{0, 20, 60, 100, 140, 180, 199, 200, 220, 239,
                           240, 260, 300, 340, 380, 420, 460, 500, 540,
                           580, 600, 620, 639, 640, 656, 751, 752};

   function automatic exp_t model(input int x, input int y);
      exp_t e;
      e.x = x;
      e.y = y;
      e.rgb = 12'h000;
      if (x < 640 && y < 480) begin
         e.rgb = m_regs[x / 40];
`ifdef VGA_BORDER_EN
         if (x == 0 || x == 639 || y == 0 || y == 479) e.rgb = 12'hFFF;
`endif
      end
      e.hs = !(x >= 656 && x < 752);
      e.vs = !(y >= 490 && y < 492);
      return e;
   endfunction

   task automatic push(input int x, input int y);
      sb.push_back(model(x, y));
   endtask

   task automatic push_line(input int y);
      for (int i = 0; i < 27; i++) push(xs[i], y);
   endtask

   task automatic drain();
      exp_t e;
      int target;
      int guard;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         target = 4 * (e.y * 800 + e.x) + 5;
         guard = 0;
         while (cyc < target && guard < 100000) begin
            @(negedge clk);
            guard++;
         end
         total++;
         assert (cyc === target) else begin
            bad++;
            $error("FAIL reach x=%0d y=%0d: cyc=%0d want %0d", e.x, e.y, cyc, target);
         end
         total++;
         assert ({vga_r, vga_g, vga_b} === e.rgb) else begin
            bad++;
            $error("FAIL rgb x=%0d y=%0d: got %h want %h", e.x, e.y,
                   {vga_r, vga_g, vga_b}, e.rgb);
         end
         total++;
         assert (vga_hsync === e.hs) else begin
            bad++;
            $error("FAIL hsync x=%0d y=%0d: got %b want %b", e.x, e.y, vga_hsync, e.hs);
         end
         total++;
         assert (vga_vsync === e.vs) else begin
            bad++;
            $error("FAIL vsync x=%0d y=%0d: got %b want %b", e.x, e.y, vga_vsync, e.vs);
         end
      end
   endtask

   task automatic chk_reset();
      total++;
      assert (vga_hsync === 1'b1) else begin
         bad++;
         $error("FAIL rst_hsync: got %b want 1", vga_hsync);
      end
      total++;
      assert (vga_vsync === 1'b1) else begin
         bad++;
         $error("FAIL rst_vsync: got %b want 1", vga_vsync);
      end
      total++;
      assert ({vga_r, vga_g, vga_b} === 12'h000) else begin
         bad++;
         $error("FAIL rst_rgb: got %h want 000", {vga_r, vga_g, vga_b});
      end
   endtask

   task automatic clr_model();
      for (int i = 0; i < 16; i++) m_regs[i] = 12'h000;
      m_addr = 4'd0;
      m_valid = 1'b0;
   endtask

   task automatic ebi_addr(input logic [15:0] a);
      @(negedge clk);
      EBI_CS = 1'b0;
      EBI_AD = a;
      EBI_ALE = 1'b0;
      repeat (4) @(negedge clk);
      EBI_ALE = 1'b1;
      repeat (4) @(negedge clk);
      m_addr = a[3:0];
      m_valid = (a[15:4] == 12'd0);
   endtask

   task automatic ebi_data(input logic [15:0] d, input logic cs);
      @(negedge clk);
      EBI_CS = cs;
      EBI_AD = d;
      EBI_WE = 1'b0;
      repeat (4) @(negedge clk);
      EBI_WE = 1'b1;
      repeat (4) @(negedge clk);
      EBI_CS = 1'b1;
      if (!cs && m_valid) m_regs[m_addr] = d[11:0];
   endtask

   initial begin
      btn_rst = 1'b0;
      EBI_AD  = 16'h0000;
      EBI_ALE = 1'b1;
      EBI_CS  = 1'b1;
      EBI_RE  = 1'b1;
      EBI_WE  = 1'b1;
      clr_model();
      repeat (5) @(negedge clk);
      chk_reset();
      @(negedge clk);
      btn_rst = 1'b1;

      push_line(0);
      drain();

      ebi_addr(16'h0005);
      ebi_data(16'h0032, 1'b0);
      ebi_addr(16'h000F);
      ebi_data(16'h001E, 1'b0);
      ebi_data(16'h0ABC, 1'b1);
      ebi_addr(16'h0015);
      ebi_data(16'h0FFF, 1'b0);
      ebi_addr(16'h0003);
      ebi_data(16'h0111, 1'b0);
      ebi_data(16'hFABC, 1'b0);

      push_line(2);
      drain();

      repeat (1000) @(negedge clk);
      btn_rst = 1'b0;
      clr_model();
      repeat (3) @(negedge clk);
      chk_reset();
      @(negedge clk);
      btn_rst = 1'b1;

      push_line(0);
      drain();

      ebi_data(16'h0777, 1'b0);
      push_line(1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
